// File: rtl/approx_mult_pipe_pkg.sv
// rtl/approx_mult_pipe_pkg.sv - mode encodings and carry-save layer sizing helpers
package approx_mult_pipe_pkg;

   localparam logic MODE_EXACT  = 1'b0;
   localparam logic MODE_APPROX = 1'b1;

   // Rows remaining after applying the given number of 3:2 layers to a matrix of this height.
   function automatic int csa_rows_after(input int height, input int layers);
      int rows;
      rows = height;
      for (int k = 0; k < layers; k++) begin
         if (rows > 2) rows = (rows / 3) * 2 + rows % 3;
      end
      return rows;
   endfunction

   function automatic int csa_layers(input int height);
      int rows;
      int n;
      rows = height;
      n    = 0;
      for (int k = 0; k < 64; k++) begin
         if (rows > 2) begin
            rows = (rows / 3) * 2 + rows % 3;
            n    = n + 1;
         end
      end
      return n;
   endfunction

endpackage

// File: rtl/approx_mult_pipe_if.sv
// rtl/approx_mult_pipe_if.sv - operand/result handshake bundle for the multiplier
interface approx_mult_pipe_if #(
   parameter int WIDTH = 16,
   parameter int TAG_W = 4
);
   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     in_a;
   logic [WIDTH-1:0]     in_b;
   logic                 in_approx;
   logic [TAG_W-1:0]     in_tag;
   logic                 out_valid;
   logic                 out_ready;
   logic [2*WIDTH-1:0]   out_prod;
   logic [TAG_W-1:0]     out_tag;
   logic                 out_approx;

   modport master (
      output in_valid, in_a, in_b, in_approx, in_tag, out_ready,
      input  in_ready, out_valid, out_prod, out_tag, out_approx
   );

   modport slave (
      input  in_valid, in_a, in_b, in_approx, in_tag, out_ready,
      output in_ready, out_valid, out_prod, out_tag, out_approx
   );
endinterface

// File: rtl/approx_mult_pipe_csa.sv
// rtl/approx_mult_pipe_csa.sv - 3:2 compressor across N columns (row of full-adder cells)
module csa_row_compressor #(
   parameter int N = 32
) (
   input  logic [N-1:0] x,
   input  logic [N-1:0] y,
   input  logic [N-1:0] z,
   output logic [N-1:0] sum,
   output logic [N-1:0] carry
);
   logic [N-1:0] maj;

   assign sum   = x ^ y ^ z;
   assign maj   = (x & y) | (x & z) | (y & z);
   // Carry is pre-shifted into the next column; the top carry falls outside the product width.
   assign carry = maj << 1;
endmodule

// File: rtl/approx_mult_pipe.sv
// rtl/approx_mult_pipe.sv - 3-stage pipelined unsigned multiplier with exact/approximate low columns
module approx_mult_pipe
   import approx_mult_pipe_pkg::*;
#(
   parameter int WIDTH       = 16,
   parameter int APPROX_COLS = 8,
   parameter int TAG_W       = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   approx_mult_pipe_if.slave  bus
);
   localparam int P  = 2 * WIDTH;
   localparam int H  = WIDTH + 1;
   localparam int LT = csa_layers(H);
   localparam int R1 = csa_rows_after(H, 1);
   localparam logic [P-1:0] LOW_MASK = P'((64'd1 << APPROX_COLS) - 64'd1);

   logic             approx_in;
   logic [P-1:0]     keep_mask;
   logic [P-1:0]     col_or;
   logic [P-1:0]     pp [0:H-1];
   logic [P-1:0]     s1_row [0:R1-1];
   logic [P-1:0]     red_sum, red_carry;
   logic [P-1:0]     s2_sum, s2_carry, s3_prod;
   logic [TAG_W-1:0] s1_tag, s2_tag, s3_tag;
   logic             s1_approx, s2_approx, s3_approx;
   logic             s1_valid, s2_valid, s3_valid;
   logic             adv1, adv2, adv3;

   assign approx_in = (bus.in_approx == MODE_APPROX);
   assign keep_mask = approx_in ? ~LOW_MASK : '1;

   // Approximated columns collapse to one OR bit, so they never generate a carry.
   always_comb begin
      col_or = '0;
      for (int i = 0; i < WIDTH; i++) begin
         for (int j = 0; j < WIDTH; j++) begin
            if (i + j < APPROX_COLS) col_or[i+j] = col_or[i+j] | (bus.in_a[i] & bus.in_b[j]);
         end
      end
   end

   for (genvar j = 0; j < WIDTH; j++) begin : g_pp
      assign pp[j] = (P'(bus.in_a & {WIDTH{bus.in_b[j]}}) << j) & keep_mask;
   end
   assign pp[WIDTH] = approx_in ? col_or : '0;

   // Layer 0 is combinational from the operands; layers 1.. run from the S1 register.
   for (genvar l = 0; l < LT; l++) begin : g_layer
      localparam int HI = csa_rows_after(H, l);
      localparam int G  = HI / 3;
      localparam int HO = csa_rows_after(H, l + 1);
      logic [P-1:0] rin  [0:H-1];
      logic [P-1:0] rout [0:H-1];

      if (l == 0) begin : g_src_pp
         assign rin = pp;
      end else if (l == 1) begin : g_src_s1
         for (genvar r = 0; r < H; r++) begin : g_row
            if (r < R1) begin : g_reg
               assign rin[r] = s1_row[r];
            end else begin : g_pad
               assign rin[r] = '0;
            end
         end
      end else begin : g_src_prev
         assign rin = g_layer[l-1].rout;
      end

      for (genvar g = 0; g < G; g++) begin : g_csa
         csa_row_compressor #(.N(P)) u_csa (
            .x     (rin[3*g]),
            .y     (rin[3*g+1]),
            .z     (rin[3*g+2]),
            .sum   (rout[2*g]),
            .carry (rout[2*g+1])
         );
      end

      for (genvar r = 2 * G; r < H; r++) begin : g_pass
         if (r < HO) begin : g_keep
            assign rout[r] = rin[r+G];
         end else begin : g_zero
            assign rout[r] = '0;
         end
      end
   end

   assign red_sum   = g_layer[LT-1].rout[0];
   assign red_carry = g_layer[LT-1].rout[1];

   assign adv3 = !s3_valid || bus.out_ready;
   assign adv2 = !s2_valid || adv3;
   assign adv1 = !s1_valid || adv2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid  <= 1'b0;
         s2_valid  <= 1'b0;
         s3_valid  <= 1'b0;
         for (int r = 0; r < R1; r++) s1_row[r] <= '0;
         s2_sum    <= '0;
         s2_carry  <= '0;
         s3_prod   <= '0;
         s1_tag    <= '0;
         s2_tag    <= '0;
         s3_tag    <= '0;
         s1_approx <= 1'b0;
         s2_approx <= 1'b0;
         s3_approx <= 1'b0;
      end else begin
         if (adv1) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
               for (int r = 0; r < R1; r++) s1_row[r] <= g_layer[0].rout[r];
               s1_tag    <= bus.in_tag;
               s1_approx <= bus.in_approx;
            end
         end
         if (adv2) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
               s2_sum    <= red_sum;
               s2_carry  <= red_carry;
               s2_tag    <= s1_tag;
               s2_approx <= s1_approx;
            end
         end
         // Data registers only move when a valid beat arrives, so a stalled result holds steady.
         if (adv3) begin
            s3_valid <= s2_valid;
            if (s2_valid) begin
               s3_prod   <= s2_sum + s2_carry;
               s3_tag    <= s2_tag;
               s3_approx <= s2_approx;
            end
         end
      end
   end

   assign bus.in_ready   = adv1;
   assign bus.out_valid  = s3_valid;
   assign bus.out_prod   = s3_prod;
   assign bus.out_tag    = s3_tag;
   assign bus.out_approx = s3_approx;
endmodule

// File: tb/tb_approx_mult_pipe.sv
// tb/tb_approx_mult_pipe.sv - self-checking bench for approx_mult_pipe
module tb_approx_mult_pipe;
   localparam int WIDTH = 16;
   localparam int K     = 8;
   localparam int TAG_W = 4;
   localparam int P     = 2 * WIDTH;

   typedef struct {
      logic [P-1:0]     prod;
      logic [TAG_W-1:0] tag;
      logic             approx;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int   n_tests = 0;
   int   n_fail  = 0;
   int   n_out   = 0;
   exp_t sb[$];
   bit   rand_ready  = 1'b0;
   logic ready_fixed = 1'b1;
   bit   w8_go   = 1'b0;
   int   w8_done = 0;

   approx_mult_pipe_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();
   approx_mult_pipe #(.WIDTH(WIDTH), .APPROX_COLS(K), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus.slave));

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Column-count reference: each column holds cnt partial-product ones.
   function automatic logic [63:0] model(input logic [63:0] a, input logic [63:0] b,
                                         input bit m, input int w, input int k);
      logic [63:0] r;
      int cnt;
      r = 64'd0;
      for (int c = 0; c < 2 * w; c++) begin
         cnt = 0;
         for (int i = 0; i < w; i++)
            if (c - i >= 0 && c - i < w) cnt += int'(a[i] & b[c-i]);
         if (m && c < k) r += (cnt > 0) ? (64'd1 << c) : 64'd0;
         else            r += 64'(cnt) << c;
      end
      return r;
   endfunction

   initial begin
      forever begin
         @(posedge clk); #2;
         bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_fixed;
      end
   end

   logic             prev_stall = 1'b0;
   logic [P-1:0]     prev_prod;
   logic [TAG_W-1:0] prev_tag;
   logic             prev_approx;

   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("stall_valid",  bus.out_valid, 1);
            check("stall_prod",   bus.out_prod, prev_prod);
            check("stall_tag",    bus.out_tag, prev_tag);
            check("stall_approx", bus.out_approx, prev_approx);
         end
         if (bus.in_valid && bus.in_ready)
            sb.push_back('{P'(model(bus.in_a, bus.in_b, bus.in_approx, WIDTH, K)), bus.in_tag, bus.in_approx});
         if (bus.out_valid && bus.out_ready) begin
            n_out++;
            if (sb.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_output: prod=0x%0h with no beat outstanding", bus.out_prod);
            end else begin
               e = sb.pop_front();
               check("out_prod",   bus.out_prod, e.prod);
               check("out_tag",    bus.out_tag, e.tag);
               check("out_approx", bus.out_approx, e.approx);
            end
         end
         prev_stall  = bus.out_valid && !bus.out_ready;
         prev_prod   = bus.out_prod;
         prev_tag    = bus.out_tag;
         prev_approx = bus.out_approx;
      end
   end

   task automatic send(input logic [15:0] a, input logic [15:0] b, input logic m,
                       input logic [3:0] t, output int tries);
      bit done;
      done  = 1'b0;
      tries = 0;
      bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b; bus.in_approx = m; bus.in_tag = t;
      while (!done && tries < 200) begin
         @(negedge clk);
         done = bus.in_ready;
         tries++;
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      if (!done) begin
         n_tests++;
         n_fail++;
         $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, expected 1", tries);
      end
   endtask

   task automatic drain();
      int c;
      c = 0;
      rand_ready  = 1'b0;
      ready_fixed = 1'b1;
      while (sb.size() != 0 && c < 200) begin
         @(negedge clk);
         c++;
      end
      check("drain_empty", sb.size(), 0);
      @(posedge clk); #1;
   endtask

   task automatic directed(input string name, input logic [15:0] a, input logic [15:0] b,
                           input logic m, input logic [63:0] exp);
      int lat;
      int tries;
      send(a, b, m, 4'hA, tries);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!bus.out_valid && lat < 10);
      check({name, "_latency"}, lat, 3);
      check({name, "_prod"}, bus.out_prod, exp);
      repeat (2) @(negedge clk);
      @(posedge clk); #1;
   endtask

   task automatic set_beat(input int idx);
      bus.in_valid  = 1'b1;
      bus.in_a      = 16'($urandom);
      bus.in_b      = 16'($urandom);
      bus.in_approx = 1'(idx % 2);
      bus.in_tag    = 4'(idx);
   endtask

   initial begin
      int tries, total, acc, base, cnt;
      bit took, took4;
      bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_approx = 1'b0; bus.in_tag = '0;
      bus.out_ready = 1'b1;

      repeat (2) @(negedge clk);
      check("rst_out_valid",  bus.out_valid, 0);
      check("rst_out_prod",   bus.out_prod, 0);
      check("rst_out_tag",    bus.out_tag, 0);
      check("rst_out_approx", bus.out_approx, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_in_ready", bus.in_ready, 1);

      check("model_ffff_exact",  model(64'hFFFF, 64'hFFFF, 0, 16, 8), 64'hFFFE0001);
      check("model_ffff_approx", model(64'hFFFF, 64'hFFFF, 1, 16, 8), 64'hFFFDF9FF);
      check("model_3x5_approx",  model(64'd3, 64'd5, 1, 16, 8), 64'd15);
      check("model_3x3_approx",  model(64'd3, 64'd3, 1, 16, 8), 64'd7);
      check("model_3x3_exact",   model(64'd3, 64'd3, 0, 16, 8), 64'd9);
      @(posedge clk); #1;

      directed("ffff_exact",  16'hFFFF, 16'hFFFF, 1'b0, 64'hFFFE0001);
      directed("ffff_approx", 16'hFFFF, 16'hFFFF, 1'b1, 64'hFFFDF9FF);
      directed("3x5_approx",  16'd3, 16'd5, 1'b1, 64'd15);
      directed("3x3_approx",  16'd3, 16'd3, 1'b1, 64'd7);
      directed("3x3_exact",   16'd3, 16'd3, 1'b0, 64'd9);

      total = 0;
      for (int i = 0; i < 20; i++) begin
         send(16'($urandom), 16'($urandom), 1'(i % 2), 4'(i), tries);
         total += tries;
      end
      check("throughput_cycles", total, 20);
      drain();

      base = n_out;
      rand_ready = 1'b1;
      for (int i = 0; i < 64; i++) send(16'($urandom), 16'($urandom), 1'(i % 2), 4'(i), tries);
      drain();
      check("stream_count", n_out - base, 64);

      ready_fixed = 1'b0;
      acc = 0;
      set_beat(0);
      repeat (6) begin
         @(negedge clk);
         took = bus.in_ready;
         @(posedge clk); #1;
         if (took) begin
            acc++;
            set_beat(acc);
         end
      end
      check("stall_accepted", acc, 3);
      @(negedge clk);
      check("stall_in_ready", bus.in_ready, 0);
      @(posedge clk); #1;
      ready_fixed = 1'b1;
      took4 = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("release_valid", bus.out_valid, 1);
         took = bus.in_ready;
         @(posedge clk); #1;
         if (took && !took4) begin
            took4 = 1'b1;
            bus.in_valid = 1'b0;
         end
      end
      bus.in_valid = 1'b0;
      check("fourth_accepted", took4, 1);
      drain();

      ready_fixed = 1'b0;
      send(16'h1234, 16'h5678, 1'b0, 4'h1, tries);
      send(16'h0F0F, 16'hF0F0, 1'b1, 4'h2, tries);
      @(posedge clk); #1;
      check("rst_pre_valid", bus.out_valid, 1);
      rst_n = 1'b0;
      #1;
      check("rst_mid_valid",  bus.out_valid, 0);
      check("rst_mid_prod",   bus.out_prod, 0);
      check("rst_mid_tag",    bus.out_tag, 0);
      check("rst_mid_approx", bus.out_approx, 0);
      sb.delete();
      ready_fixed = 1'b1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      cnt = 0;
      repeat (8) begin
         @(negedge clk);
         if (bus.out_valid) cnt++;
      end
      check("rst_no_stale", cnt, 0);
      @(posedge clk); #1;

      w8_go = 1'b1;
      for (int c = 0; c < 20000 && w8_done < 8; c++) @(negedge clk);
      check("w8_all_done", w8_done, 8);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // WIDTH=8, APPROX_COLS=0: eight instances split the 65536 pairs per mode between them.
   for (genvar g = 0; g < 8; g++) begin : g_w8
      approx_mult_pipe_if #(.WIDTH(8), .TAG_W(4)) wb ();
      approx_mult_pipe #(.WIDTH(8), .APPROX_COLS(0), .TAG_W(4)) u_w8 (
         .clk(clk), .rst_n(rst_n), .bus(wb.slave));
      logic [15:0] wq[$];

      initial begin
         bit took;
         int p;
         wb.in_valid = 1'b0; wb.in_a = '0; wb.in_b = '0; wb.in_tag = '0;
         wb.in_approx = 1'(g % 2);
         wb.out_ready = 1'b1;
         wait (w8_go);
         @(posedge clk); #1;
         p = 0;
         while (p < 16384) begin
            wb.in_valid = 1'b1;
            wb.in_a = 8'((g / 2) * 64 + p / 256);
            wb.in_b = 8'(p % 256);
            @(negedge clk);
            took = wb.in_ready;
            if (took) wq.push_back(16'(wb.in_a) * 16'(wb.in_b));
            @(posedge clk); #1;
            if (took) p++;
         end
         wb.in_valid = 1'b0;
         for (int c = 0; c < 20 && wq.size() > 0; c++) @(negedge clk);
         check("w8_drain", wq.size(), 0);
         w8_done++;
      end

      always @(negedge clk) begin
         if (rst_n && wb.out_valid && wb.out_ready) begin
            if (wq.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL w8_unexpected: prod=0x%0h with no beat outstanding", wb.out_prod);
            end else begin
               check("w8_prod", wb.out_prod, wq.pop_front());
            end
         end
      end
   end
endmodule
